// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/MEM-stage memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int FE_DATA_W = 32;
  localparam int BE_W      = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_FE  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one RAM port, with MEM priority
// bounded by a starvation limit and fetch flush (kill) support.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FE_REQ,
  input  logic [ADDR_W-1:0]    FE_ADDR,
  input  logic                 FE_FLUSH,
  output logic                 FE_GNT,
  output logic                 FE_DONE,
  output logic [FE_DATA_W-1:0] FE_RDATA,
  input  logic                 MEM_REQ,
  input  logic                 MEM_WE,
  input  logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic [DATA_W-1:0]    MEM_WDATA,
  input  logic [BE_W-1:0]      MEM_BE,
  output logic                 MEM_GNT,
  output logic                 MEM_DONE,
  output logic [DATA_W-1:0]    MEM_RDATA,
  output logic                 RAM_REQ,
  output logic                 RAM_WE,
  output logic [ADDR_W-1:0]    RAM_ADDR,
  output logic [DATA_W-1:0]    RAM_WDATA,
  output logic [BE_W-1:0]      RAM_BE,
  input  logic                 RAM_ACK,
  input  logic [DATA_W-1:0]    RAM_RDATA
);
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             kill;
  logic             fe_hi;
  logic             fe_win;
  logic             unused_fe_addr;

  // Fetch is word-aligned to 8 bytes; only bit 2 picks the returned half.
  assign unused_fe_addr = ^FE_ADDR[1:0];
  assign fe_win = FE_REQ && (!MEM_REQ || starve_cnt == LIMIT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      starve_cnt <= '0;
      kill       <= 1'b0;
      fe_hi      <= 1'b0;
      FE_GNT     <= 1'b0;
      FE_DONE    <= 1'b0;
      FE_RDATA   <= '0;
      MEM_GNT    <= 1'b0;
      MEM_DONE   <= 1'b0;
      MEM_RDATA  <= '0;
      RAM_REQ    <= 1'b0;
      RAM_WE     <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      RAM_BE     <= '0;
    end else begin
      FE_GNT   <= 1'b0;
      MEM_GNT  <= 1'b0;
      FE_DONE  <= 1'b0;
      MEM_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (fe_win) begin
            FE_GNT     <= 1'b1;
            RAM_REQ    <= 1'b1;
            RAM_WE     <= 1'b0;
            RAM_ADDR   <= {FE_ADDR[ADDR_W-1:3], 3'b000};
            RAM_BE     <= '1;
            fe_hi      <= FE_ADDR[2];
            starve_cnt <= '0;
            state      <= BUSY_FE;
          end else if (MEM_REQ) begin
            MEM_GNT   <= 1'b1;
            RAM_REQ   <= 1'b1;
            RAM_WE    <= MEM_WE;
            RAM_ADDR  <= MEM_ADDR;
            RAM_WDATA <= MEM_WDATA;
            RAM_BE    <= MEM_BE;
            if (FE_REQ && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
            state     <= BUSY_MEM;
          end
        end
        BUSY_FE: begin
          if (RAM_ACK) begin
            RAM_REQ <= 1'b0;
            // A flush on the completing cycle also suppresses the result.
            if (!(kill || FE_FLUSH)) begin
              FE_DONE  <= 1'b1;
              FE_RDATA <= fe_hi ? RAM_RDATA[63:32] : RAM_RDATA[31:0];
            end
            kill  <= 1'b0;
            state <= IDLE;
          end else if (FE_FLUSH) begin
            kill <= 1'b1;
          end
        end
        BUSY_MEM: begin
          if (RAM_ACK) begin
            RAM_REQ   <= 1'b0;
            MEM_DONE  <= 1'b1;
            MEM_RDATA <= RAM_RDATA;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation, flush, reset.
module tb_mem_port_arbiter;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        FE_REQ, FE_FLUSH, FE_GNT, FE_DONE;
  logic [63:0] FE_ADDR;
  logic [31:0] FE_RDATA;
  logic        MEM_REQ, MEM_WE, MEM_GNT, MEM_DONE;
  logic [63:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [7:0]  MEM_BE;
  logic        RAM_REQ, RAM_WE, RAM_ACK;
  logic [63:0] RAM_ADDR, RAM_WDATA, RAM_RDATA;
  logic [7:0]  RAM_BE;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .FE_REQ(FE_REQ), .FE_ADDR(FE_ADDR), .FE_FLUSH(FE_FLUSH),
    .FE_GNT(FE_GNT), .FE_DONE(FE_DONE), .FE_RDATA(FE_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
    .MEM_GNT(MEM_GNT), .MEM_DONE(MEM_DONE), .MEM_RDATA(MEM_RDATA),
    .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_BE(RAM_BE),
    .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; FE_REQ = 0; FE_ADDR = '0; FE_FLUSH = 0;
    MEM_REQ = 0; MEM_WE = 0; MEM_ADDR = '0; MEM_WDATA = '0; MEM_BE = '0;
    RAM_ACK = 0; RAM_RDATA = '0;
    tick(); tick();
    chk("rst_ram_req", RAM_REQ, 0);
    chk("rst_ram_be", RAM_BE, 0);
    chk("rst_fe_rdata", FE_RDATA, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    RESET = 1'b0;

    // Single fetch, ACK two cycles after grant, upper word returned
    FE_REQ = 1; FE_ADDR = 64'h1004;
    tick();
    chk("fe_gnt", FE_GNT, 1);
    chk("fe_ram_req", RAM_REQ, 1);
    chk("fe_ram_addr", RAM_ADDR, 64'h1000);
    chk("fe_ram_we", RAM_WE, 0);
    chk("fe_ram_be", RAM_BE, 8'hFF);
    FE_REQ = 0; FE_ADDR = 64'hFFFF;
    tick();
    chk("fe_gnt_pulse", FE_GNT, 0);
    chk("fe_addr_stable", RAM_ADDR, 64'h1000);
    chk("fe_no_done_early", FE_DONE, 0);
    RAM_ACK = 1; RAM_RDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("fe_done", FE_DONE, 1);
    chk("fe_rdata_hi", FE_RDATA, 32'hAAAABBBB);
    chk("fe_ram_req_drop", RAM_REQ, 0);
    RAM_ACK = 0; RAM_RDATA = '0;
    tick();
    chk("fe_done_pulse", FE_DONE, 0);
    chk("fe_rdata_hold", FE_RDATA, 32'hAAAABBBB);

    // Simultaneous requests: MEM store wins, FE served right after
    FE_REQ = 1; FE_ADDR = 64'h2000;
    MEM_REQ = 1; MEM_WE = 1; MEM_ADDR = 64'h3008; MEM_WDATA = 64'h0123_4567_89AB_CDEF; MEM_BE = 8'h0F;
    tick();
    chk("both_mem_gnt", MEM_GNT, 1);
    chk("both_fe_gnt0", FE_GNT, 0);
    chk("st_ram_we", RAM_WE, 1);
    chk("st_ram_be", RAM_BE, 8'h0F);
    chk("st_ram_addr", RAM_ADDR, 64'h3008);
    chk("st_ram_wdata", RAM_WDATA, 64'h0123_4567_89AB_CDEF);
    chk("starve_1", dut.starve_cnt, 1);
    MEM_REQ = 0; MEM_WE = 0;
    RAM_ACK = 1; RAM_RDATA = 64'h5555_6666_7777_8888;
    tick();
    chk("st_mem_done", MEM_DONE, 1);
    chk("st_mem_rdata", MEM_RDATA, 64'h5555_6666_7777_8888);
    chk("no_gnt_on_ack", FE_GNT, 0);
    RAM_ACK = 0;
    tick();
    chk("fe_after_mem", FE_GNT, 1);
    chk("fe_after_addr", RAM_ADDR, 64'h2000);
    chk("starve_clr", dut.starve_cnt, 0);
    FE_REQ = 0;
    RAM_ACK = 1; RAM_RDATA = 64'h1111_2222_3333_4444;
    tick();
    chk("fe_lo_done", FE_DONE, 1);
    chk("fe_rdata_lo", FE_RDATA, 32'h33334444);
    chk("mem_rdata_hold", MEM_RDATA, 64'h5555_6666_7777_8888);
    RAM_ACK = 0;

    // Starvation: FE held, MEM keeps re-requesting
    FE_REQ = 1; FE_ADDR = 64'h4000;
    MEM_REQ = 1; MEM_ADDR = 64'h5000;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("starve_mem_gnt%0d", i), MEM_GNT, 1);
      chk($sformatf("starve_cnt%0d", i), dut.starve_cnt, i);
      RAM_ACK = 1;
      tick();
      chk($sformatf("starve_mem_done%0d", i), MEM_DONE, 1);
      RAM_ACK = 0;
    end
    tick();
    chk("starve_fe_gnt", FE_GNT, 1);
    chk("starve_mem_gnt0", MEM_GNT, 0);
    chk("starve_cnt_clr", dut.starve_cnt, 0);
    FE_REQ = 0; MEM_REQ = 0;
    RAM_ACK = 1; RAM_RDATA = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    chk("starve_fe_rdata", FE_RDATA, 32'h0BADF00D);
    RAM_ACK = 0;

    // Flush one cycle after grant kills the fetch result
    FE_REQ = 1; FE_ADDR = 64'h6004;
    tick();
    chk("fl_gnt", FE_GNT, 1);
    FE_REQ = 0; FE_FLUSH = 1;
    tick();
    FE_FLUSH = 0;
    RAM_ACK = 1; RAM_RDATA = 64'h9999_8888_7777_6666;
    tick();
    chk("fl_no_done", FE_DONE, 0);
    chk("fl_ram_req_drop", RAM_REQ, 0);
    chk("fl_rdata_keep", FE_RDATA, 32'h0BADF00D);
    RAM_ACK = 0;
    tick();
    chk("fl_no_done2", FE_DONE, 0);
    // Kill must not leak into the next fetch
    FE_REQ = 1; FE_ADDR = 64'h7000;
    tick();
    FE_REQ = 0;
    RAM_ACK = 1; RAM_RDATA = 64'h0000_0000_1234_5678;
    tick();
    chk("fl_next_done", FE_DONE, 1);
    chk("fl_next_rdata", FE_RDATA, 32'h12345678);
    RAM_ACK = 0;

    // Reset in BUSY_MEM before ACK; late ACK ignored
    MEM_REQ = 1; MEM_WE = 0; MEM_ADDR = 64'h40;
    tick();
    chk("rm_gnt", MEM_GNT, 1);
    MEM_REQ = 0;
    tick();
    RESET = 1;
    #1;
    chk("rm_ram_req_async", RAM_REQ, 0);
    chk("rm_rdata_clr", MEM_RDATA, 0);
    tick();
    RESET = 0; RAM_ACK = 1; RAM_RDATA = 64'hFEED;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ack_idle_mem_done%0d", i), MEM_DONE, 0);
      chk($sformatf("ack_idle_fe_done%0d", i), FE_DONE, 0);
      chk($sformatf("ack_idle_ram_req%0d", i), RAM_REQ, 0);
    end
    chk("ack_idle_rdata", MEM_RDATA, 0);
    RAM_ACK = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
